// File: rtl/rv32i_pkg.sv
// Shared RV32I core constants and types used by the PC register and its neighbours.
// Latency: none (declarations only).
// Backpressure: none (declarations only).
package rv32i_pkg;

    localparam int XLEN        = 32;
    localparam int INSTR_BYTES = 4;

    typedef logic [XLEN-1:0] addr_t;

    localparam addr_t RESET_VECTOR = 32'h0000_0000;

endpackage : rv32i_pkg

// File: rtl/rv32i_pc_reg_if.sv
// Bundle between the next-PC mux and the PC register, including the derived outputs.
// Latency: none (wires only).
// Backpressure: none; the PC loads every cycle, so there is no handshake.
interface rv32i_pc_reg_if #(
    parameter int XLEN = rv32i_pkg::XLEN
);

    logic [XLEN-1:0] pc_next;
    logic [XLEN-1:0] pc_current;
    logic [XLEN-1:0] pc_plus4;
    logic [XLEN-1:0] pc_prev;
    logic            misaligned;

    // Next-PC selection side: supplies pc_next and consumes the PC views.
    modport master (
        output pc_next,
        input  pc_current,
        input  pc_plus4,
        input  pc_prev,
        input  misaligned
    );

    // PC register side.
    modport slave (
        input  pc_next,
        output pc_current,
        output pc_plus4,
        output pc_prev,
        output misaligned
    );

endinterface : rv32i_pc_reg_if

// File: rtl/rv32i_pc_reg.sv
// Program-counter register: holds the fetch PC, the previous PC, PC+4 and an alignment flag.
// Latency: pc_next appears on pc_current one cycle later; pc_plus4/misaligned are combinational.
// Backpressure: none; the PC loads on every rising edge outside reset.
module rv32i_pc_reg #(
    parameter int              XLEN         = rv32i_pkg::XLEN,
    parameter logic [XLEN-1:0] RESET_VECTOR = XLEN'(rv32i_pkg::RESET_VECTOR)
) (
    input  logic              clk,
    input  logic              rst,
    rv32i_pc_reg_if.slave     pc_if
);

    logic [XLEN-1:0] pc_q;
    logic [XLEN-1:0] pc_d;
    logic [XLEN-1:0] prev_q;
    logic [XLEN-1:0] prev_d;

    // Next state: take the mux output unmodified and remember the outgoing PC.
    always_comb begin
        pc_d   = pc_if.pc_next;
        prev_d = pc_q;
    end

    // Both PC registers share one async reset so they come out of reset aligned.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc_q   <= RESET_VECTOR;
            prev_q <= RESET_VECTOR;
        end else begin
            pc_q   <= pc_d;
            prev_q <= prev_d;
        end
    end

    // Derived views: sequential address wraps modulo 2^XLEN; misalignment is flagged, not trapped.
    always_comb begin
        pc_if.pc_current = pc_q;
        pc_if.pc_prev    = prev_q;
        pc_if.pc_plus4   = pc_q + XLEN'(rv32i_pkg::INSTR_BYTES);
        pc_if.misaligned = (pc_q[1:0] != 2'b00);
    end

endmodule : rv32i_pc_reg

// File: tb/tb_rv32i_pc_reg.sv
// Self-checking bench for rv32i_pc_reg using an expected-value scoreboard.
// Latency: one cycle per load is modelled.
// Backpressure: not applicable.
module tb_rv32i_pc_reg;
    import rv32i_pkg::*;

    typedef struct packed {
        addr_t cur;
        addr_t prev;
        addr_t plus4;
        logic  mis;
    } exp_t;

    logic   clk;
    logic   rst;
    int     checks;
    int     errors;
    exp_t   sb[$];
    addr_t  mdl_cur;
    addr_t  mdl_prev;

    rv32i_pc_reg_if #(.XLEN(XLEN)) pc_if ();

    rv32i_pc_reg #(.XLEN(XLEN), .RESET_VECTOR(RESET_VECTOR)) dut (
        .clk   (clk),
        .rst   (rst),
        .pc_if (pc_if)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%08h exp=%08h", tag, got, exp);
        end
    endtask

    // Drive one pc_next value, push the expected post-edge state, then pop and compare after the edge.
    task automatic step(input addr_t nxt);
        exp_t e;
        exp_t g;
        pc_if.pc_next = nxt;
        e.cur   = nxt;
        e.prev  = mdl_cur;
        e.plus4 = nxt + 32'd4;
        e.mis   = (nxt[1:0] != 2'b00);
        sb.push_back(e);
        mdl_prev = mdl_cur;
        mdl_cur  = nxt;
        @(posedge clk);
        #1;
        if (sb.size() == 0) begin
            chk("sb_empty", 32'd0, 32'd1);
        end else begin
            g = sb.pop_front();
            chk("cur",   pc_if.pc_current,       g.cur);
            chk("prev",  pc_if.pc_prev,          g.prev);
            chk("plus4", pc_if.pc_plus4,         g.plus4);
            chk("mis",   {31'd0, pc_if.misaligned}, {31'd0, g.mis});
        end
    endtask

    initial begin
        checks   = 0;
        errors   = 0;
        mdl_cur  = 32'h0;
        mdl_prev = 32'h0;
        rst      = 1'b1;
        pc_if.pc_next = 32'h0;

        // Reset at time 0 before any edge.
        #1;
        chk("rst_cur",   pc_if.pc_current, 32'h0000_0000);
        chk("rst_prev",  pc_if.pc_prev,    32'h0000_0000);
        chk("rst_plus4", pc_if.pc_plus4,   32'h0000_0004);
        chk("rst_mis",   {31'd0, pc_if.misaligned}, 32'd0);

        // Hold reset through an edge with a junk pc_next: must be ignored.
        pc_if.pc_next = 32'h1234_5678;
        @(posedge clk);
        #1;
        chk("rst_hold_cur", pc_if.pc_current, 32'h0000_0000);
        rst = 1'b0;

        // First edge after release loads immediately, then sequential loads.
        step(32'h0000_0004);
        step(32'h0000_0008);
        step(32'h0000_000C);
        step(32'h0000_0010);
        chk("seq_plus4", pc_if.pc_plus4, 32'h0000_0014);

        // Async reset mid-cycle discards the in-flight pc_next.
        pc_if.pc_next = 32'hDEAD_BEEF;
        #2;
        rst = 1'b1;
        #1;
        chk("async_cur",  pc_if.pc_current, 32'h0000_0000);
        chk("async_prev", pc_if.pc_prev,    32'h0000_0000);
        mdl_cur  = 32'h0;
        mdl_prev = 32'h0;
        @(posedge clk);
        #1;
        chk("async_hold_cur", pc_if.pc_current, 32'h0000_0000);
        rst = 1'b0;
        step(32'h0000_0020);

        // Wrap of the sequential address and unmasked misaligned store.
        step(32'hFFFF_FFFC);
        chk("wrap_plus4", pc_if.pc_plus4, 32'h0000_0000);
        chk("wrap_mis",   {31'd0, pc_if.misaligned}, 32'd0);
        step(32'h0000_0006);
        chk("mis_flag", {31'd0, pc_if.misaligned}, 32'd1);
        chk("mis_cur",  pc_if.pc_current, 32'h0000_0006);

        // Reset released exactly on a rising edge: that edge must not load.
        rst = 1'b1;
        pc_if.pc_next = 32'h0000_0040;
        #1;
        chk("coinc_rst_cur", pc_if.pc_current, 32'h0000_0000);
        @(posedge clk);
        // Nonblocking so the flop samples rst still high at this edge, as a synchronous release would.
        rst <= 1'b0;
        #1;
        chk("coinc_edge_cur",  pc_if.pc_current, 32'h0000_0000);
        chk("coinc_edge_prev", pc_if.pc_prev,    32'h0000_0000);
        @(posedge clk);
        #1;
        chk("coinc_next_cur",  pc_if.pc_current, 32'h0000_0040);
        chk("coinc_next_prev", pc_if.pc_prev,    32'h0000_0000);

        chk("sb_drained", sb.size(), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule : tb_rv32i_pc_reg
